hc_stream_reader: RTL and testbench
===================================

HC_STREAM_READER -- requirements
Module: hc_stream_reader

Interface
REQ-001 Parameter: CHUNK_CL, default 8, maximum cache lines per stream read request (1..1024).
REQ-002 Parameter: FIFO_DEPTH, default 64, response FIFO entries; power of two, >= CHUNK_CL.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  stream descriptor valid.
REQ-006 cmd_ready  out  1  descriptor accepted when cmd_valid&&cmd_ready.
REQ-007 cmd_id  in  4  buffer id to read.
REQ-008 cmd_len  in  32  total cache lines to read.
REQ-009 req_valid  out  1  one-cycle strobe; enqueue one e_REQUEST_READ_STREAM into the requestor read-request queue.
REQ-010 req_id  out  4  buffer id of the request.
REQ-011 req_len  out  11  cache lines in the request (offset field).
REQ-012 req_full  in  1  requestor read-request queue status.full.
REQ-013 rsp_valid  in  1  requestor rx_buffer_data.valid.
REQ-014 rsp_data  in  512  requestor rx_buffer_data.cl_data.
REQ-015 out_valid / out_ready  out / in  1 / 1  user data handshake.
REQ-016 out_data  out  512  cache line to user.
REQ-017 out_last  out  1  marks final line of the descriptor.
REQ-018 busy  out  1  high from descriptor accept until done.
REQ-019 done  out  1  one-cycle pulse when the final line is transferred out.
REQ-020 err  out  1  sticky: response arrived with zero lines outstanding.

Function
REQ-021 FSM states S_IDLE, S_ISSUE, S_DRAIN; cmd_ready=1 only in S_IDLE.
REQ-022 S_IDLE: on accept, latch id and len; remaining=len, outstanding_total=len; go to S_ISSUE; if len==0, go to S_IDLE and pulse done the next cycle with no requests and no output.
REQ-023 S_ISSUE: chunk=min(remaining, CHUNK_CL); issue when !req_full and credit>=chunk, credit=FIFO_DEPTH-fifo_count-inflight.
REQ-024 On issue: req_valid=1 for exactly one cycle, req_len=chunk, remaining-=chunk, inflight+=chunk; at most one issue per cycle.
REQ-025 S_ISSUE->S_DRAIN in the cycle remaining reaches 0.
REQ-026 Each rsp_valid pushes rsp_data into the FIFO and decrements inflight; arrival order is preserved; no reordering.
REQ-027 Credit rule guarantees no FIFO overflow; a push and a pop in the same cycle leave the count unchanged.
REQ-028 out_valid=FIFO not empty; pop on out_valid&&out_ready; out_data stable while out_valid&&!out_ready.
REQ-029 Delivered-line counter increments on each pop; out_last=1 when the counter equals len-1 and out_valid.
REQ-030 S_DRAIN->S_IDLE on the pop with out_last; done pulses the following cycle, busy falls with done.
REQ-031 rsp_valid while inflight==0: data dropped, err set; cleared only by reset.
REQ-032 Counters (remaining, inflight, delivered) are 32-bit unsigned; inflight never exceeds FIFO_DEPTH.

Reset
REQ-033 Reset asserted at any time: state=S_IDLE, FIFO emptied, all counters 0, latched id/len 0.
REQ-034 Reset values: cmd_ready=1 after release, req_valid=0, req_id=0, req_len=0, out_valid=0, out_last=0, busy=0, done=0, err=0.
REQ-035 Reset mid-stream abandons the descriptor; responses arriving after release set err.

Configuration
REQ-036 Macro HC_STREAM_READER_PERF_EN: when defined, adds outputs perf_cycles (32) counting busy cycles and perf_stall (32) counting S_ISSUE cycles blocked by req_full or credit. Both clear on descriptor accept, saturate at all-ones and reset to 0.
REQ-037 Without HC_STREAM_READER_PERF_EN: those ports and counters are absent; all other behaviour is identical.

Verification
REQ-038 len=20, CHUNK_CL=8, out_ready=1, immediate responses -> req_len 8,8,4; 20 lines out in order; out_last on line 20; one done pulse.
REQ-039 len=0 -> no req_valid, no out_valid, done pulse one cycle after accept.
REQ-040 len=200, FIFO_DEPTH=64, out_ready=0 -> issue stops when inflight+count=64; release out_ready -> issue resumes; 200 lines total, no overflow.
REQ-041 req_full held high for 50 cycles mid-stream -> no req_valid during hold; perf_stall >= 50 (macro on); stream completes correctly.
REQ-042 rsp_valid pulse in S_IDLE -> err=1, out_valid stays 0; reset -> err=0.
REQ-043 Reset asserted with 16 lines in flight -> all outputs at reset values next cycle; a new len=4 descriptor completes normally.

Source files
------------

// File: rtl/hc_stream_reader.sv
// Streams a buffer out of the host cache in CHUNK_CL-line read requests and replays the responses in order.
// Optional performance counters are enabled by defining HC_STREAM_READER_PERF_EN.
module hc_stream_reader #(
    parameter int CHUNK_CL   = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_id,
    input  logic [31:0]  cmd_len,
    output logic         req_valid,
    output logic [3:0]   req_id,
    output logic [10:0]  req_len,
    input  logic         req_full,
    input  logic         rsp_valid,
    input  logic [511:0] rsp_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         err
`ifdef HC_STREAM_READER_PERF_EN
    ,
    output logic [31:0]  perf_cycles,
    output logic [31:0]  perf_stall
`endif
);

    localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW      = AW + 1;
    localparam logic [31:0] CHUNK_W = 32'(CHUNK_CL);
    localparam logic [31:0] DEPTH_W = 32'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t        state_q;
    logic [3:0]    id_q;
    logic [31:0]   len_q;
    logic [31:0]   remaining_q;
    logic [31:0]   inflight_q,  inflight_d;
    logic [31:0]   delivered_q, delivered_d;
    logic          req_valid_q;
    logic [3:0]    req_id_q;
    logic [10:0]   req_len_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [511:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          accept;
    logic [31:0]   chunk;
    logic [31:0]   credit;
    logic          issue;
    logic          push;
    logic          stray;
    logic          pop;
    logic          pop_last;

    assign accept   = cmd_valid && (state_q == S_IDLE);
    assign chunk    = (remaining_q < CHUNK_W) ? remaining_q : CHUNK_W;
    // Space not yet promised to a request; FIFO count plus inflight never exceeds the depth.
    assign credit   = DEPTH_W - 32'(count_q) - inflight_q;
    assign issue    = (state_q == S_ISSUE) && !req_full && (credit >= chunk);
    assign push     = rsp_valid && (inflight_q != 32'd0);
    assign stray    = rsp_valid && (inflight_q == 32'd0);
    assign pop      = out_valid && out_ready;
    assign pop_last = pop && out_last;

    assign cmd_ready = (state_q == S_IDLE);
    assign req_valid = req_valid_q;
    assign req_id    = req_id_q;
    assign req_len   = req_len_q;
    assign out_valid = (count_q != '0);
    assign out_data  = fifo_mem[rd_ptr_q];
    assign out_last  = out_valid && (delivered_q == len_q - 32'd1);
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        inflight_d  = inflight_q;
        delivered_d = delivered_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        if (issue) begin
            inflight_d = inflight_d + chunk;
        end
        if (push) begin
            inflight_d = inflight_d - 32'd1;
            wr_ptr_d   = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        if (accept) begin
            delivered_d = 32'd0;
        end else if (pop) begin
            delivered_d = delivered_q + 32'd1;
        end
    end

    // Storage has no reset; occupancy lives entirely in the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= rsp_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q  <= 32'd0;
            delivered_q <= 32'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            inflight_q  <= inflight_d;
            delivered_q <= delivered_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            id_q        <= 4'd0;
            len_q       <= 32'd0;
            remaining_q <= 32'd0;
            req_valid_q <= 1'b0;
            req_id_q    <= 4'd0;
            req_len_q   <= 11'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (stray) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        id_q        <= cmd_id;
                        len_q       <= cmd_len;
                        remaining_q <= cmd_len;
                        if (cmd_len == 32'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        req_valid_q <= 1'b1;
                        req_id_q    <= id_q;
                        req_len_q   <= chunk[10:0];
                        remaining_q <= remaining_q - chunk;
                        if (remaining_q == chunk) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop_last) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef HC_STREAM_READER_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles_q <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else if (accept) begin
            perf_cycles_q <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else begin
            if (busy_q && (perf_cycles_q != 32'hFFFF_FFFF)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if ((state_q == S_ISSUE) && !issue && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_hc_stream_reader.sv
// Randomized bench for hc_stream_reader: a queue-based model of the response stream plus chunking arithmetic.
module tb_hc_stream_reader;

    localparam int unsigned CHUNK = 8;
    localparam int unsigned DEPTH = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_id = 4'd0;
    logic [31:0]  cmd_len = 32'd0;
    logic         req_valid;
    logic [3:0]   req_id;
    logic [10:0]  req_len;
    logic         req_full = 1'b0;
    logic         rsp_valid = 1'b0;
    logic [511:0] rsp_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [511:0] out_data;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         err;
`ifdef HC_STREAM_READER_PERF_EN
    logic [31:0]  perf_cycles;
    logic [31:0]  perf_stall;
`endif

    always #5 clk = ~clk;

    hc_stream_reader #(.CHUNK_CL(CHUNK), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .req_valid(req_valid), .req_id(req_id), .req_len(req_len), .req_full(req_full),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
`ifdef HC_STREAM_READER_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    int unsigned total_cnt = 0;
    int unsigned bad_cnt   = 0;

    // Model: lines the responder owes, lines buffered for the user, and the descriptor position.
    logic [511:0] exp_q[$];
    int unsigned  pend = 0, rem = 0, cur_len = 0, cur_id = 0, delivered = 0, nreq = 0, cyc = 0;
    bit           busy_x = 0, done_x = 0, err_x = 0, hold_full = 0, rsp_real = 0;
    int unsigned  rdy_pct = 100, rsp_pct = 100, full_pct = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        bit acc, pop, push, real_p, full_e, last_pop;
        logic [511:0] pdata;
        int unsigned acc_len, acc_id, chunk;
        acc      = cmd_valid && cmd_ready;
        acc_len  = cmd_len;
        acc_id   = cmd_id;
        pop      = out_valid && out_ready;
        push     = rsp_valid;
        real_p   = rsp_real;
        pdata    = rsp_data;
        full_e   = req_full;
        last_pop = pop && (cur_len != 0) && (delivered == cur_len - 1);
        @(posedge clk);
        #1;
        cyc++;
        if (pop && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            delivered++;
        end
        if (push) begin
            if (real_p) exp_q.push_back(pdata);
            else err_x = 1'b1;
        end
        done_x = 1'b0;
        if (acc) begin
            cur_len = acc_len; cur_id = acc_id; rem = acc_len;
            delivered = 0; nreq = 0;
            busy_x = (acc_len != 0);
            done_x = (acc_len == 0);
        end else if (last_pop) begin
            done_x = 1'b1;
            busy_x = 1'b0;
        end
        check_eq("busy", busy, busy_x);
        check_eq("done", done, done_x);
        check_eq("err", err, err_x);
        check_eq("cmd_ready", cmd_ready, !busy_x);
        check_eq("out_valid", out_valid, exp_q.size() != 0);
        if (out_valid && exp_q.size() != 0) begin
            check_eq("out_data", out_data, exp_q[0]);
            check_eq("out_last", out_last, (cur_len != 0) && (delivered == cur_len - 1));
        end
        if (req_valid) begin
            chunk = (rem > CHUNK) ? CHUNK : rem;
            nreq++;
            check_eq("req_len", req_len, chunk);
            check_eq("req_id", req_id, cur_id);
            check_eq("req_gated_by_full", full_e, 1'b0);
            rem  -= chunk;
            pend += chunk;
            check_eq("no_overflow", (pend + exp_q.size()) <= DEPTH, 1'b1);
        end
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        if (pend != 0 && $urandom_range(0, 99) < rsp_pct) begin
            rsp_valid = 1'b1; rsp_real = 1'b1; rsp_data = rand_line(); pend--;
        end else begin
            rsp_valid = 1'b0; rsp_real = 1'b0;
        end
        req_full = hold_full || ($urandom_range(0, 99) < full_pct);
    endtask

    task automatic start_desc(input int unsigned len);
        int unsigned n;
        n = 0;
        while (!cmd_ready && n < 5000) begin step(); n++; end
        check_eq("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_id    = 4'($urandom);
        cmd_len   = len;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_desc(input int unsigned len, input int unsigned limit);
        int unsigned n, c0;
        n  = 0;
        c0 = cyc;
        if (len != 0) begin
            while (!done && n < limit) begin step(); n++; end
            check_eq("done_seen", done, 1'b1);
        end
        repeat (3) step();
        check_eq("lines", delivered, len);
        check_eq("req_count", nreq, (len + CHUNK - 1) / CHUNK);
        $display("desc id=%0d len=%0d reqs=%0d lines=%0d cycles=%0d", cur_id, len, nreq, delivered, cyc - c0);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; rsp_valid = 1'b0; rsp_real = 1'b0;
        out_ready = 1'b0; req_full = 1'b0; hold_full = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_req_valid", req_valid, 1'b0);
        check_eq("rst_req_id", req_id, 4'd0);
        check_eq("rst_req_len", req_len, 11'd0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_last", out_last, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
`ifdef HC_STREAM_READER_PERF_EN
        check_eq("rst_perf_cycles", perf_cycles, 32'd0);
        check_eq("rst_perf_stall", perf_stall, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        pend = 0; rem = 0; cur_len = 0; cur_id = 0; delivered = 0; nreq = 0;
        busy_x = 1'b0; done_x = 1'b0; err_x = 1'b0;
    endtask

    initial begin
        int unsigned n, len;
        #2;
        do_reset();

        // Basic chunking: 20 lines -> 8, 8, 4
        rdy_pct = 100; rsp_pct = 100; full_pct = 0;
        start_desc(20);
        wait_desc(20, 500);

        // Empty descriptor
        start_desc(0);
        wait_desc(0, 10);

        // Backpressure fills the FIFO to exactly its depth, then drains
        rdy_pct = 0; rsp_pct = 100;
        start_desc(200);
        repeat (150) step();
        check_eq("fill_level", exp_q.size(), DEPTH);
        check_eq("fill_remaining", rem, 200 - DEPTH);
        rdy_pct = 100;
        wait_desc(200, 3000);

        // Requestor queue full for 50 cycles mid-stream
        rdy_pct = 70; rsp_pct = 60;
        start_desc(400);
        repeat (20) step();
        hold_full = 1'b1;
        repeat (51) step();
        hold_full = 1'b0;
`ifdef HC_STREAM_READER_PERF_EN
        check_eq("perf_stall_min", perf_stall >= 32'd50, 1'b1);
`endif
        wait_desc(400, 5000);

        // Randomized descriptors
        for (int k = 0; k < 6; k++) begin
            rdy_pct  = $urandom_range(30, 100);
            rsp_pct  = $urandom_range(30, 100);
            full_pct = $urandom_range(0, 30);
            len      = $urandom_range(1, 150);
            start_desc(len);
            wait_desc(len, 5000);
        end
        full_pct = 0;

        // Stray response while idle
        rsp_valid = 1'b1; rsp_real = 1'b0; rsp_data = rand_line();
        step();
        step();
        do_reset();

        // Reset with lines in flight, then late responses and a fresh descriptor
        rdy_pct = 0; rsp_pct = 0;
        start_desc(40);
        n = 0;
        while (pend < 16 && n < 100) begin step(); n++; end
        check_eq("inflight_16", pend >= 16, 1'b1);
        do_reset();
        rsp_valid = 1'b1; rsp_real = 1'b0; rsp_data = rand_line();
        step();
        step();
        do_reset();
        rdy_pct = 100; rsp_pct = 100;
        start_desc(4);
        wait_desc(4, 200);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
